handle_fifo_ctrl: RTL and testbench

//  FIFO controller that sits in front of the dual-port handle RAM (1-cycle registered read,
//  old-data-on-collision). It owns the write and read pointers and drives the RAM ports.
//  It presents a valid/ready show-ahead interface on both sides and sustains one handle per cycle.
//  A 2-entry output buffer hides the RAM read latency.

---
 rtl/handle_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_handle_fifo_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handle_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// handle_fifo_ctrl
//   FIFO controller in front of a dual-port handle RAM with a 1-cycle
//   registered read. It owns the write/read pointers, drives the RAM ports and
//   presents show-ahead valid/ready interfaces on both sides. A 2-entry output
//   buffer hides the RAM read latency, so one handle per cycle is sustained.
//
// Ports
//   clk, rst, flush        clock, sync active-high reset, one-cycle sync clear
//   in_data/valid/ready    producer side; transfer on in_valid & in_ready
//   out_data/valid/ready   consumer side; pop on out_valid & out_ready
//   ram_wdata/waddr/we     RAM write port
//   ram_raddr, ram_q       RAM read port; ram_q valid one cycle after raddr
//   usedw                  RAM entries + in-flight read + output buffer entries
//   full                   RAM holds DEPTH entries
//   empty                  usedw == 0
// ---------------------------------------------------------------------------
module handle_fifo_ctrl #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  full,
  output logic                  empty
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Pointers carry one extra MSB so full (diff == DEPTH) and empty (diff == 0)
  // are distinguishable after wrap.
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         ram_cnt;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [1:0]            ob_keep;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;   // head of the output buffer
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;
  logic [2:0]            committed;
  logic                  clr, push, pop, issue;

  assign clr = rst | flush;

  always_comb begin
    ram_cnt  = wr_ptr_q - rd_ptr_q;
    in_ready = ~clr & (ram_cnt < DEPTH_P);
    push     = in_valid & in_ready;
    out_valid = (ob_cnt_q != 2'd0);
    pop       = out_valid & out_ready;

    // Slots of the output buffer already spoken for after this cycle's pop.
    // A read is only issued if its data is guaranteed a slot on arrival.
    // ram_cnt excludes this cycle's write, so raddr never equals waddr.
    committed = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    issue     = (ram_cnt != '0) && (committed < 3'd2);

    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(issue);
    inflight_d = issue;

    // Output buffer: shift on pop, then append arriving RAM data behind
    // whatever entries remain.
    ob0_d   = ob0_q;
    ob1_d   = ob1_q;
    ob_keep = ob_cnt_q - 2'(pop);
    if (pop) ob0_d = ob1_q;
    if (inflight_q) begin
      if (ob_keep == 2'd0) ob0_d = ram_q;
      else                 ob1_d = ram_q;
    end
    ob_cnt_d = ob_keep + 2'(inflight_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;   // drops any read still in flight
      ob_cnt_q   <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
    end
  end

  // Data registers need no reset; ob_cnt_q qualifies them.
  always_ff @(posedge clk) begin
    ob0_q <= ob0_d;
    ob1_q <= ob1_d;
  end

  assign out_data  = ob0_q;
  assign ram_we    = push;
  assign ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wdata = in_data;
  assign ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign usedw     = ram_cnt + PW'(inflight_q) + PW'(ob_cnt_q);
  assign full      = (ram_cnt == DEPTH_P);
  assign empty     = (usedw == '0);

  a_no_write_when_full: assert property (@(posedge clk) disable iff (clr)
    !(ram_we && (ram_cnt == DEPTH_P)));
  a_ob_bound: assert property (@(posedge clk) disable iff (clr)
    (3'(ob_cnt_q) + 3'(inflight_q)) <= 3'd2);
  a_usedw_bound: assert property (@(posedge clk) disable iff (clr)
    usedw <= PW'(DEPTH + 2));

endmodule

// File: tb/tb_handle_fifo_ctrl.sv
module tb_handle_fifo_ctrl;
  localparam int DW = 40;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic          ram_we, full, empty;
  logic [DW-1:0] in_data, out_data, ram_wdata, ram_q;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW:0]   usedw;

  always #5 clk = ~clk;

  handle_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_wdata(ram_wdata), .ram_waddr(ram_waddr), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .ram_q(ram_q),
    .usedw(usedw), .full(full), .empty(empty)
  );

  // RAM model: registered read, old data on same-address collision.
  logic [DW-1:0] mem [1<<AW];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  initial ram_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  int            errors = 0, checks = 0;
  logic [DW-1:0] exp_q [$];
  bit            sb_en = 1'b0;
  int            acc = 0, rcv = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / monitor: outputs sampled mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (sb_en) begin
      chk("usedw_vs_model", 64'(usedw), 64'(exp_q.size()));
      chk("empty_vs_model", 64'(empty), 64'(exp_q.size() == 0));
      if (exp_q.size() >= 18) begin
        chk("in_ready_at_cap", 64'(in_ready), 64'd0);
        chk("full_at_cap", 64'(full), 64'd1);
      end
      if (exp_q.size() <= 15) begin
        chk("in_ready_space", 64'(in_ready), 64'd1);
        chk("full_space", 64'(full), 64'd0);
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_underflow", 64'(out_data), 64'hDEAD);
        else chk("sb_data", 64'(out_data), 64'(exp_q.pop_front()));
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    logic rst, flush, iv;
    logic [DW-1:0] d;
    logic ordy;
    logic e_ir, e_we, e_ov;
    logic [DW-1:0] e_od;
    logic [AW:0] e_u;
    logic e_empty, e_full;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic r, fl, iv, input logic [DW-1:0] d, input logic ordy,
                     input logic ir, we, ov, input logic [DW-1:0] od,
                     input logic [AW:0] u, input logic e, f);
    vec_t v;
    v.rst = r; v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = ir; v.e_we = we; v.e_ov = ov; v.e_od = od;
    v.e_u = u; v.e_empty = e; v.e_full = f;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic drain(input string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    mid();
    chk(nm, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  localparam logic [DW-1:0] D1 = 40'h12_3456_789A;
  localparam logic [DW-1:0] X1 = 40'hAA_0000_0001;
  localparam logic [DW-1:0] Y1 = 40'hAA_0000_0002;
  localparam logic [DW-1:0] Z1 = 40'hAA_0000_0003;

  initial begin
    int a0, r0, guard, seen_ov;
    bit got_first, saw_full;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();

    // rows = cycles 0..15: rst, flush, iv, data, ordy | in_ready, we, ov, od, usedw, empty, full
    add(1,0,0,'0,1, 0,0,0,'0,0,1,0);
    for (int i = 1; i <= 4; i++) add(0,0,0,'0,1, 1,0,0,'0,0,1,0);
    add(0,0,1,D1,1, 1,1,0,'0,0,1,0);   // push at cycle 5
    add(0,0,0,'0,1, 1,0,0,'0,1,0,0);
    add(0,0,0,'0,1, 1,0,0,'0,1,0,0);
    add(0,0,0,'0,1, 1,0,1,D1,1,0,0);   // visible at cycle 8
    add(0,0,0,'0,1, 1,0,0,'0,0,1,0);   // empty at cycle 9
    add(0,0,1,X1,1, 1,1,0,'0,0,1,0);
    add(0,0,1,Y1,0, 1,1,0,'0,1,0,0);
    add(0,1,1,Z1,0, 0,0,0,'0,2,0,0);   // flush blocks the push
    for (int i = 13; i <= 15; i++) add(0,0,0,'0,0, 1,0,0,'0,0,1,0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
      in_data = tbl[i].d; out_ready = tbl[i].ordy;
      mid();
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_ram_we", i), 64'(ram_we), 64'(tbl[i].e_we));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_od));
      chk($sformatf("tbl%0d_usedw", i), 64'(usedw), 64'(tbl[i].e_u));
      chk($sformatf("tbl%0d_empty", i), 64'(empty), 64'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].e_full));
      tick();
    end
    rst = 1'b0; flush = 1'b0;

    // Fill with a stalled consumer: DEPTH + 2 words.
    exp_q.delete(); sb_en = 1'b1;
    a0 = acc; out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1; in_data = 40'h20_0000_0000 + 40'(acc);
      tick();
    end
    mid();
    chk("fill_count", 64'(acc - a0), 64'd18);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_usedw", 64'(usedw), 64'd18);
    tick();
    drain("fill_drain");

    // Streaming: continuous push/pop, no bubbles, occupancy 3.
    a0 = acc; r0 = rcv; got_first = 1'b0; guard = 0;
    out_ready = 1'b1;
    while ((rcv - r0) < 100 && guard < 400) begin
      in_valid = ((acc - a0) < 100);
      in_data  = 40'h30_0000_0000 + 40'(acc - a0);
      mid();
      if (got_first && (rcv - r0) < 100) chk("stream_bubble", 64'(out_valid), 64'd1);
      if (out_valid) got_first = 1'b1;
      if (got_first && in_valid) chk("stream_usedw", 64'(usedw), 64'd3);
      tick();
      guard++;
    end
    chk("stream_done", 64'(rcv - r0), 64'd100);
    drain("stream_drain");

    // Random valid/ready.
    a0 = acc; r0 = rcv; guard = 0;
    while ((rcv - r0) < 2000 && guard < 20000) begin
      in_valid  = ((acc - a0) < 2000) && ($urandom_range(0, 1) == 1);
      in_data   = 40'({$urandom(), $urandom()});
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      guard++;
    end
    chk("rand_done", 64'(rcv - r0), 64'd2000);
    drain("rand_drain");

    // Bursty consumer across pointer wrap.
    a0 = acc; r0 = rcv; guard = 0; saw_full = 1'b0;
    while ((rcv - r0) < 40 && guard < 400) begin
      in_valid  = ((acc - a0) < 40);
      in_data   = 40'h50_0000_0000 + 40'(acc - a0);
      out_ready = ((guard / 20) % 2) == 1;
      mid();
      if (full) saw_full = 1'b1;
      tick();
      guard++;
    end
    chk("wrap_done", 64'(rcv - r0), 64'd40);
    chk("wrap_saw_full", 64'(saw_full), 64'd1);
    mid();
    chk("wrap_empty", 64'(empty), 64'd1);
    tick();

    // Reset with a read in flight and one buffered entry.
    sb_en = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h60_0000_00AA; tick();
    in_data = 40'h60_0000_00BB; tick();
    in_valid = 1'b0; tick();
    rst = 1'b1;
    mid();
    chk("prerst_out_valid", 64'(out_valid), 64'd1);
    chk("prerst_out_data", 64'(out_data), 64'h60_0000_00AA);
    chk("prerst_usedw", 64'(usedw), 64'd2);
    tick();
    rst = 1'b0;
    mid();
    chk("postrst_out_valid", 64'(out_valid), 64'd0);
    chk("postrst_usedw", 64'(usedw), 64'd0);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    chk("postrst_empty", 64'(empty), 64'd1);
    tick();
    seen_ov = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      if (out_valid) seen_ov++;
      tick();
    end
    chk("postrst_no_stale", 64'(seen_ov), 64'd0);
    exp_q.delete(); sb_en = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 40'h00_00C0_FFEE;
    tick();
    r0 = rcv;
    drain("postrst_drain");
    chk("postrst_recv", 64'(rcv - r0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
